tlb_req_sched: RTL and testbench
================================

Name: tlb_req_sched

Overview:
- Shares one TLB lookup/insert port between two requesters: port 0 is instruction fetch, port 1 is data access.
- Round-robin arbitrates, issues the lookup, and on a miss drives a page-walk request with a timeout.
- Inserts the walked translation into the TLB, returns a response to the winning requester, and sequences TLB flushes (shutdown).
- Sits between the core's I/D address sources and the TLB set/way storage.

Parameters:
SADDR, 64, address width in bits
SPAGE, 12, page-offset width in bits
SPCID, 12, PCID width in bits
WALK_TIMEOUT, 256, max cycles waiting for walk_ack before faulting (>=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset: one clock; reset is asynchronous and active-low
req_valid  in  2  per-requester request valid
req_va  in  2*SADDR  per-requester VA; requester i uses bits [i*SADDR +: SADDR]
req_pcid  in  2*SPCID  per-requester PCID; requester i uses bits [i*SPCID +: SPCID]
req_ready  out  2  per-requester accept, combinational
rsp_valid  out  2  one-cycle response pulse to the granted requester
rsp_pa  out  SADDR  translated address, valid with rsp_valid
rsp_fault  out  1  translation failed, valid with rsp_valid
flush_req  in  1  request full TLB flush, level or pulse
flush_done  out  1  one-cycle pulse when flush complete
tlb_req  out  1  one-cycle lookup strobe
tlb_va  out  SADDR  lookup/insert VA, registered
tlb_pcid  out  SPCID  lookup/insert PCID, registered
tlb_rsp_valid  in  1  lookup result valid, earliest cycle after tlb_req
tlb_hit  in  1  lookup hit, qualified by tlb_rsp_valid
tlb_ta  in  SADDR  translated address on hit
tlb_insert  out  1  one-cycle insert strobe
tlb_pa  out  SADDR  physical address to insert
tlb_shutdown  out  1  one-cycle flush strobe to TLB
walk_req  out  1  page-walk request, held until ack or timeout
walk_va  out  SADDR  walk VA
walk_pcid  out  SPCID  walk PCID
walk_ack  in  1  walk complete
walk_pa  in  SADDR  walked PA; only bits [SADDR-1:SPAGE] are used
walk_fault  in  1  walk found no valid mapping, qualified by walk_ack

Behaviour:
- Reset (rst_n low, async): all outputs 0, including tlb_va, tlb_pcid, tlb_pa, rsp_pa and all strobes.
- Reset also sets: state=IDLE, rr_last=1 (so port 0 wins first), flush_pend=0, walk counter=0.
- Deasserting rst_n mid-operation abandons any in-flight request; no response is issued for it.

States: IDLE, LOOKUP, WAIT_TLB, WALK, INSERT, RESP, FLUSH.

- flush_pend is set by flush_req in any state and cleared on entry to FLUSH.
- IDLE with flush_pend or flush_req high: req_ready=0; next state FLUSH.
- IDLE otherwise:
  - grant = the valid port other than rr_last; if only one port is valid, it wins.
  - req_ready[grant]=1; req_ready is 0 in all other states.
  - On valid&ready: capture VA, PCID and id into tlb_va/tlb_pcid/cur_id; go to LOOKUP.
- LOOKUP: tlb_req=1 for exactly one cycle, then go to WAIT_TLB.
- WAIT_TLB: wait for tlb_rsp_valid.
  - Hit: rsp_pa <= tlb_ta, rsp_fault <= 0, go to RESP.
  - Miss: counter <= 0, go to WALK.
- WALK: walk_req=1, with walk_va=tlb_va and walk_pcid=tlb_pcid; the counter increments each cycle.
  - walk_ack & walk_fault: rsp_fault <= 1, rsp_pa <= 0, go to RESP. No insert.
  - walk_ack & !walk_fault: tlb_pa <= {walk_pa[SADDR-1:SPAGE], tlb_va[SPAGE-1:0]}; rsp_pa gets the same value; go to INSERT.
  - No ack and counter == WALK_TIMEOUT-1: fault as above and drop walk_req. A walk_ack arriving in that same cycle wins over the timeout.
- INSERT: tlb_insert=1 for one cycle with tlb_va, tlb_pcid, tlb_pa stable, then go to RESP.
- RESP: rsp_valid[cur_id]=1 for one cycle, rr_last <= cur_id, go to IDLE.
- FLUSH: tlb_shutdown=1 for one cycle; flush_done=1 in the following cycle (IDLE). A flush never interrupts an in-flight request.
- Hit latency: accept at cycle T, tlb_req at T+1. With tlb_rsp_valid at T+2, rsp_valid is at T+3.
- tlb_rsp_valid, walk_ack or walk_fault arriving outside their wait state is ignored.

Test Plan:
- Single hit: port0 va=0x0000_1234_5678, pcid=5. TLB returns hit at T+2 with ta=0xABCD_E678 -> req_ready[0] at T, tlb_req at T+1, rsp_valid[0] at T+3 with rsp_pa=0xABCD_E678 and rsp_fault=0.
- Miss+walk: tlb_hit=0, walk_ack after 10 cycles with walk_pa=0x7_7000. Expect:
  - walk_req held 10 cycles.
  - tlb_insert pulse with tlb_pa=0x7_7678.
  - rsp_valid[1] with rsp_pa=0x7_7678.
- Walk fault/timeout:
  - walk_fault with ack -> rsp_fault=1, no tlb_insert.
  - No ack with WALK_TIMEOUT=8 -> walk_req high exactly 8 cycles, then rsp_fault=1.
- Round-robin: both ports valid continuously -> grants alternate 0,1,0,1. A single valid port is granted on every IDLE.
- Flush: flush_req pulses during WALK -> request completes normally, then tlb_shutdown is asserted for one cycle, flush_done the next, and only then is req_ready re-asserted.
- Reset: rst_n low during WALK -> all outputs 0 asynchronously. After release: no rsp_valid for the abandoned request, and port 0 is granted first.

Source files
------------

// File: rtl/tlb_req_sched_if.sv
// tlb_req_sched_if: bundles every non-clock/reset signal of tlb_req_sched.
//   Requester side : req_valid/req_va/req_pcid in, req_ready/rsp_* out
//   Flush          : flush_req in, flush_done out
//   TLB side       : tlb_req/tlb_va/tlb_pcid/tlb_insert/tlb_pa/tlb_shutdown out,
//                    tlb_rsp_valid/tlb_hit/tlb_ta in
//   Walker side    : walk_req/walk_va/walk_pcid out, walk_ack/walk_pa/walk_fault in
// modport slave is the scheduler's view; modport master is the environment's
// view (requesters, TLB storage and page walker). SADDR/SPCID must match the
// values given to the scheduler instance.
interface tlb_req_sched_if #(
   parameter int SADDR = 64,
   parameter int SPCID = 12
);
   logic [1:0]         req_valid;
   logic [2*SADDR-1:0] req_va;
   logic [2*SPCID-1:0] req_pcid;
   logic [1:0]         req_ready;
   logic [1:0]         rsp_valid;
   logic [SADDR-1:0]   rsp_pa;
   logic               rsp_fault;
   logic               flush_req;
   logic               flush_done;
   logic               tlb_req;
   logic [SADDR-1:0]   tlb_va;
   logic [SPCID-1:0]   tlb_pcid;
   logic               tlb_rsp_valid;
   logic               tlb_hit;
   logic [SADDR-1:0]   tlb_ta;
   logic               tlb_insert;
   logic [SADDR-1:0]   tlb_pa;
   logic               tlb_shutdown;
   logic               walk_req;
   logic [SADDR-1:0]   walk_va;
   logic [SPCID-1:0]   walk_pcid;
   logic               walk_ack;
   logic [SADDR-1:0]   walk_pa;
   logic               walk_fault;

   modport slave (
      input  req_valid, req_va, req_pcid, flush_req,
      input  tlb_rsp_valid, tlb_hit, tlb_ta,
      input  walk_ack, walk_pa, walk_fault,
      output req_ready, rsp_valid, rsp_pa, rsp_fault, flush_done,
      output tlb_req, tlb_va, tlb_pcid, tlb_insert, tlb_pa, tlb_shutdown,
      output walk_req, walk_va, walk_pcid
   );

   modport master (
      output req_valid, req_va, req_pcid, flush_req,
      output tlb_rsp_valid, tlb_hit, tlb_ta,
      output walk_ack, walk_pa, walk_fault,
      input  req_ready, rsp_valid, rsp_pa, rsp_fault, flush_done,
      input  tlb_req, tlb_va, tlb_pcid, tlb_insert, tlb_pa, tlb_shutdown,
      input  walk_req, walk_va, walk_pcid
   );
endinterface

// File: rtl/tlb_req_sched.sv
// tlb_req_sched: shares one TLB lookup/insert port between instruction fetch
// (port 0) and data access (port 1). Round-robin grants a requester, issues the
// lookup, runs a page walk with timeout on a miss, inserts the walked
// translation, returns a one-cycle response, and sequences full TLB flushes
// between requests.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tlb_req_sched_if.slave (requester, flush, TLB and walker signals)
module tlb_req_sched #(
   parameter int SADDR        = 64,
   parameter int SPAGE        = 12,
   parameter int SPCID        = 12,
   parameter int WALK_TIMEOUT = 256
) (
   input  logic           clk,
   input  logic           rst_n,
   tlb_req_sched_if.slave bus
);
   localparam int CW = (WALK_TIMEOUT > 2) ? $clog2(WALK_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WAIT_TLB, WALK, INSERT, RESP, FLUSH
   } state_t;

   state_t           state;
   logic             rr_last;
   logic             flush_pend;
   logic             cur_id;
   logic [CW-1:0]    walk_cnt;
   logic [1:0]       rsp_valid;
   logic [SADDR-1:0] rsp_pa;
   logic             rsp_fault;
   logic             flush_done;
   logic             tlb_req;
   logic [SADDR-1:0] tlb_va;
   logic [SPCID-1:0] tlb_pcid;
   logic             tlb_insert;
   logic [SADDR-1:0] tlb_pa;
   logic             tlb_shutdown;
   logic             walk_req;

   logic             flush_go;
   logic             gnt_id;
   logic [1:0]       req_ready;
   logic             accept;
   logic [SADDR-1:0] gnt_va;
   logic [SPCID-1:0] gnt_pcid;
   logic [SADDR-1:0] walked_pa;
   logic             walk_unused;

   assign flush_go    = flush_pend | bus.flush_req;
   assign walked_pa   = {bus.walk_pa[SADDR-1:SPAGE], tlb_va[SPAGE-1:0]};
   assign walk_unused = ^bus.walk_pa[SPAGE-1:0];

   // With both ports valid the one not served last wins; a lone valid port
   // always wins.
   always_comb begin
      gnt_id    = (bus.req_valid == 2'b11) ? ~rr_last : bus.req_valid[1];
      req_ready = '0;
      if (state == IDLE && !flush_go && (|bus.req_valid))
         req_ready[gnt_id] = 1'b1;
   end

   assign accept   = |(req_ready & bus.req_valid);
   assign gnt_va   = gnt_id ? bus.req_va[2*SADDR-1:SADDR]   : bus.req_va[SADDR-1:0];
   assign gnt_pcid = gnt_id ? bus.req_pcid[2*SPCID-1:SPCID] : bus.req_pcid[SPCID-1:0];

   // Strobes are registered alongside the state that owns them, so each is
   // set on the transition into its state and cleared by default afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_last      <= 1'b1;
         flush_pend   <= 1'b0;
         cur_id       <= 1'b0;
         walk_cnt     <= '0;
         rsp_valid    <= '0;
         rsp_pa       <= '0;
         rsp_fault    <= 1'b0;
         flush_done   <= 1'b0;
         tlb_req      <= 1'b0;
         tlb_va       <= '0;
         tlb_pcid     <= '0;
         tlb_insert   <= 1'b0;
         tlb_pa       <= '0;
         tlb_shutdown <= 1'b0;
         walk_req     <= 1'b0;
      end else begin
         tlb_req      <= 1'b0;
         tlb_insert   <= 1'b0;
         tlb_shutdown <= 1'b0;
         flush_done   <= 1'b0;
         rsp_valid    <= '0;
         if (bus.flush_req)
            flush_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (flush_go) begin
                  flush_pend   <= 1'b0;
                  tlb_shutdown <= 1'b1;
                  state        <= FLUSH;
               end else if (accept) begin
                  tlb_va   <= gnt_va;
                  tlb_pcid <= gnt_pcid;
                  cur_id   <= gnt_id;
                  tlb_req  <= 1'b1;
                  state    <= LOOKUP;
               end
            end
            LOOKUP: state <= WAIT_TLB;
            WAIT_TLB: begin
               if (bus.tlb_rsp_valid) begin
                  if (bus.tlb_hit) begin
                     rsp_pa    <= bus.tlb_ta;
                     rsp_fault <= 1'b0;
                     rsp_valid <= {cur_id, ~cur_id};
                     state     <= RESP;
                  end else begin
                     walk_cnt <= '0;
                     walk_req <= 1'b1;
                     state    <= WALK;
                  end
               end
            end
            WALK: begin
               // An ack in the final timeout cycle takes priority.
               if (bus.walk_ack && !bus.walk_fault) begin
                  walk_req   <= 1'b0;
                  tlb_pa     <= walked_pa;
                  rsp_pa     <= walked_pa;
                  rsp_fault  <= 1'b0;
                  tlb_insert <= 1'b1;
                  state      <= INSERT;
               end else if (bus.walk_ack || walk_cnt == CW'(WALK_TIMEOUT - 1)) begin
                  walk_req  <= 1'b0;
                  rsp_pa    <= '0;
                  rsp_fault <= 1'b1;
                  rsp_valid <= {cur_id, ~cur_id};
                  state     <= RESP;
               end else begin
                  walk_cnt <= walk_cnt + 1'b1;
               end
            end
            INSERT: begin
               rsp_valid <= {cur_id, ~cur_id};
               state     <= RESP;
            end
            RESP: begin
               rr_last <= cur_id;
               state   <= IDLE;
            end
            FLUSH: begin
               flush_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready    = req_ready;
   assign bus.rsp_valid    = rsp_valid;
   assign bus.rsp_pa       = rsp_pa;
   assign bus.rsp_fault    = rsp_fault;
   assign bus.flush_done   = flush_done;
   assign bus.tlb_req      = tlb_req;
   assign bus.tlb_va       = tlb_va;
   assign bus.tlb_pcid     = tlb_pcid;
   assign bus.tlb_insert   = tlb_insert;
   assign bus.tlb_pa       = tlb_pa;
   assign bus.tlb_shutdown = tlb_shutdown;
   assign bus.walk_req     = walk_req;
   assign bus.walk_va      = tlb_va;
   assign bus.walk_pcid    = tlb_pcid;
endmodule

// File: tb/tb_tlb_req_sched.sv
// Bench for tlb_req_sched: directed scenarios followed by random transactions,
// each checked against a transaction-level model of grant order, latency and
// response contents.
module tb_tlb_req_sched;
   localparam int SADDR = 64;
   localparam int SPAGE = 12;
   localparam int SPCID = 12;
   localparam int TO    = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tlb_req_sched_if #(.SADDR(SADDR), .SPCID(SPCID)) bus ();

   tlb_req_sched #(
      .SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID), .WALK_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int  n_cmp = 0;
   int  n_mis = 0;
   bit  m_rr_last;     // model: port served most recently
   bit  m_flush_pend;  // model: flush requested while busy

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full request: present vmask, answer the lookup after tlb_lat cycles,
   // answer the walk (if any) after walk_lat cycles of walk_req, check all.
   task automatic do_txn(input logic [1:0] vmask,
                         input logic [63:0] va0, input logic [63:0] va1,
                         input logic [11:0] pc0, input logic [11:0] pc1,
                         input bit hit, input int tlb_lat, input logic [63:0] ta,
                         input int walk_lat, input bit wfault, input logic [63:0] wpa,
                         input bit flush_mid);
      bit          id;
      logic [63:0] va, exp_pa;
      logic [11:0] pc;
      int          n, exp_n;
      bit          done, to_fault;
      id = (vmask == 2'b11) ? ~m_rr_last : vmask[1];
      va = id ? va1 : va0;
      pc = id ? pc1 : pc0;
      @(negedge clk);
      bus.req_valid = vmask;
      bus.req_va    = {va1, va0};
      bus.req_pcid  = {pc1, pc0};
      #1;
      chk("req_ready", 64'(bus.req_ready), id ? 64'd2 : 64'd1);
      chk("rsp_idle", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      bus.req_valid = 2'b00;
      chk("tlb_req", 64'(bus.tlb_req), 64'd1);
      chk("tlb_va", bus.tlb_va, va);
      chk("tlb_pcid", 64'(bus.tlb_pcid), 64'(pc));
      for (int k = 1; k < tlb_lat; k++) begin
         @(negedge clk);
         bus.walk_ack   = 1'($urandom_range(0, 1));
         bus.walk_fault = 1'($urandom_range(0, 1));
         chk("tlb_req_once", 64'(bus.tlb_req), 64'd0);
      end
      @(negedge clk);
      bus.walk_ack      = 1'b0;
      bus.walk_fault    = 1'b0;
      bus.tlb_rsp_valid = 1'b1;
      bus.tlb_hit       = hit;
      bus.tlb_ta        = ta;
      @(negedge clk);
      bus.tlb_rsp_valid = 1'b0;
      bus.tlb_hit       = 1'b0;
      if (hit) begin
         chk("hit_rsp_valid", 64'(bus.rsp_valid), id ? 64'd2 : 64'd1);
         chk("hit_rsp_pa", bus.rsp_pa, ta);
         chk("hit_rsp_fault", 64'(bus.rsp_fault), 64'd0);
         chk("hit_no_walk", 64'(bus.walk_req), 64'd0);
      end else begin
         n = 0;
         done = 0;
         for (int c = 0; c < TO + 4 && !done; c++) begin
            if (bus.walk_req) begin
               n++;
               if (n == 1) begin
                  chk("walk_va", bus.walk_va, va);
                  chk("walk_pcid", 64'(bus.walk_pcid), 64'(pc));
               end
               if (n == walk_lat) begin
                  bus.walk_ack   = 1'b1;
                  bus.walk_fault = wfault;
                  bus.walk_pa    = wpa;
               end
               if (flush_mid && n == 2) begin
                  bus.flush_req = 1'b1;
                  m_flush_pend  = 1'b1;
               end
               @(negedge clk);
               bus.walk_ack   = 1'b0;
               bus.walk_fault = 1'b0;
               bus.flush_req  = 1'b0;
            end else begin
               done = 1;
            end
         end
         to_fault = (walk_lat > TO);
         exp_n    = to_fault ? TO : walk_lat;
         chk("walk_req_cycles", 64'(n), 64'(exp_n));
         if (to_fault || wfault) begin
            chk("flt_no_insert", 64'(bus.tlb_insert), 64'd0);
            chk("flt_rsp_valid", 64'(bus.rsp_valid), id ? 64'd2 : 64'd1);
            chk("flt_rsp_fault", 64'(bus.rsp_fault), 64'd1);
            chk("flt_rsp_pa", bus.rsp_pa, 64'd0);
         end else begin
            exp_pa = {wpa[63:SPAGE], va[SPAGE-1:0]};
            chk("ins_strobe", 64'(bus.tlb_insert), 64'd1);
            chk("ins_tlb_pa", bus.tlb_pa, exp_pa);
            chk("ins_tlb_va", bus.tlb_va, va);
            chk("ins_no_rsp", 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
            chk("walk_rsp_valid", 64'(bus.rsp_valid), id ? 64'd2 : 64'd1);
            chk("walk_rsp_pa", bus.rsp_pa, exp_pa);
            chk("walk_rsp_fault", 64'(bus.rsp_fault), 64'd0);
            chk("ins_once", 64'(bus.tlb_insert), 64'd0);
         end
      end
      m_rr_last = id;
   endtask

   // Flush ordering after a request: ready withheld, shutdown, done, ready back.
   task automatic chk_flush();
      @(negedge clk);
      bus.req_valid = 2'b01;
      #1;
      chk("flush_ready_held", 64'(bus.req_ready), 64'd0);
      chk("flush_rsp_once", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      chk("flush_shutdown", 64'(bus.tlb_shutdown), 64'd1);
      chk("flush_ready_held2", 64'(bus.req_ready), 64'd0);
      chk("flush_done_early", 64'(bus.flush_done), 64'd0);
      @(negedge clk);
      chk("flush_done", 64'(bus.flush_done), 64'd1);
      chk("flush_shutdown_once", 64'(bus.tlb_shutdown), 64'd0);
      chk("flush_ready_back", 64'(bus.req_ready), 64'd1);
      #1;
      bus.req_valid = 2'b00;
      m_flush_pend  = 1'b0;
   endtask

   initial begin
      logic [63:0] r0, r1, rt, rw;
      rst_n = 1'b0;
      bus.req_valid = '0; bus.req_va = '0; bus.req_pcid = '0; bus.flush_req = 1'b0;
      bus.tlb_rsp_valid = 1'b0; bus.tlb_hit = 1'b0; bus.tlb_ta = '0;
      bus.walk_ack = 1'b0; bus.walk_pa = '0; bus.walk_fault = 1'b0;
      m_rr_last = 1'b1;
      m_flush_pend = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_strobes", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.flush_done,
          bus.tlb_req, bus.tlb_insert, bus.tlb_shutdown, bus.walk_req}), 64'd0);
      chk("rst_tlb_va", bus.tlb_va, 64'd0);
      chk("rst_tlb_pa", bus.tlb_pa, 64'd0);
      chk("rst_rsp_pa", bus.rsp_pa, 64'd0);
      rst_n = 1'b1;

      // Single hit on port 0
      do_txn(2'b01, 64'h0000_1234_5678, 64'h0, 12'd5, 12'd0,
             1'b1, 1, 64'hABCD_E678, 0, 1'b0, 64'h0, 1'b0);
      // Miss + walk on port 1, ack after 10 cycles
      do_txn(2'b10, 64'h0, 64'h0000_0009_8765_4678, 12'd0, 12'd9,
             1'b0, 1, 64'h0, 10, 1'b0, 64'h7_7000, 1'b0);
      // Walk fault with ack
      do_txn(2'b01, 64'h0000_0000_0040_1abc, 64'h0, 12'd3, 12'd0,
             1'b0, 2, 64'h0, 3, 1'b1, 64'h5_5000, 1'b0);
      // Walk timeout
      do_txn(2'b10, 64'h0, 64'h0000_7fff_0000_0123, 12'd0, 12'd1,
             1'b0, 1, 64'h0, 100, 1'b0, 64'h0, 1'b0);
      // Ack in the last timeout cycle wins
      do_txn(2'b01, 64'h0000_0000_1111_2345, 64'h0, 12'd7, 12'd0,
             1'b0, 1, 64'h0, TO, 1'b0, 64'hdead_b000, 1'b0);
      // Round-robin with both ports valid, then a lone port repeatedly
      for (int i = 0; i < 4; i++)
         do_txn(2'b11, 64'h1000 + 64'(i), 64'h2000 + 64'(i), 12'd1, 12'd2,
                1'b1, 1, 64'h3000 + 64'(i), 0, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 2; i++)
         do_txn(2'b10, 64'h0, 64'h4000 + 64'(i), 12'd0, 12'd4,
                1'b1, 1, 64'h5000 + 64'(i), 0, 1'b0, 64'h0, 1'b0);
      // Flush pulse during a walk
      do_txn(2'b01, 64'h0000_0000_0abc_d678, 64'h0, 12'd6, 12'd0,
             1'b0, 1, 64'h0, 6, 1'b0, 64'h9_9000, 1'b1);
      chk("flush_seen", 64'(m_flush_pend), 64'd1);
      chk_flush();

      // Reset during a walk: request from port 1, abandon mid-walk
      @(negedge clk);
      bus.req_valid = 2'b10; bus.req_va = {64'h0000_0000_0bad_0123, 64'h0}; bus.req_pcid = '0;
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      bus.tlb_rsp_valid = 1'b1; bus.tlb_hit = 1'b0;
      @(negedge clk);
      bus.tlb_rsp_valid = 1'b0;
      chk("rst_walk_active", 64'(bus.walk_req), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_strobes", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.flush_done,
          bus.tlb_req, bus.tlb_insert, bus.tlb_shutdown, bus.walk_req}), 64'd0);
      chk("arst_tlb_va", bus.tlb_va, 64'd0);
      chk("arst_walk_va", bus.walk_va, 64'd0);
      chk("arst_tlb_pa", bus.tlb_pa, 64'd0);
      chk("arst_rsp_pa", bus.rsp_pa, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_rr_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.walk_ack = 1'b1;
         bus.tlb_rsp_valid = 1'b1;
         @(negedge clk);
         chk("abandoned_no_rsp", 64'({bus.rsp_valid, bus.walk_req, bus.tlb_insert}), 64'd0);
      end
      bus.walk_ack = 1'b0;
      bus.tlb_rsp_valid = 1'b0;
      do_txn(2'b11, 64'h6000, 64'h7000, 12'd1, 12'd2,
             1'b1, 1, 64'h8000, 0, 1'b0, 64'h0, 1'b0);

      // Random transactions
      for (int i = 0; i < 40; i++) begin
         r0 = {$urandom, $urandom};
         r1 = {$urandom, $urandom};
         rt = {$urandom, $urandom};
         rw = {$urandom, $urandom};
         do_txn(2'($urandom_range(1, 3)), r0, r1, 12'($urandom), 12'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(1, 4), rt,
                $urandom_range(1, 11), ($urandom_range(0, 3) == 0), rw, 1'b0);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      n_mis++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $fatal(1, "watchdog expired");
   end
endmodule
